// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with frame-synchronous shadow/active data commit.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic [7:0]  disp_mask,
  input  logic [7:0]  dp_mask,
`ifdef SEG_BLINK_EN
  input  logic [7:0]  blink_mask,
`endif
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [7:0]  an_out,
  output logic [7:0]  seg_out
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BEND = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK, SHOW} st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          fresh_q;
  logic [31:0]   act_q, sh_q;
  logic          pend_q;
  logic          boundary, dark;
  logic [7:0]    an_d, seg_d;
  logic [3:0]    nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // The very first BLANK of idx 0 after reset is not a frame boundary.
  assign boundary = (st_q == BLANK) && (idx_q == 3'd0) && (cnt_q == '0) && !fresh_q;
  assign nib      = act_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt_q;
  logic          blink_q;

  // The first boundary only starts the count; the phase flips every BLINK_FRAMES after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (boundary) begin
      if (fcnt_q == FW'(BLINK_FRAMES)) begin
        fcnt_q  <= FW'(1);
        blink_q <= ~blink_q;
      end else begin
        fcnt_q  <= fcnt_q + FW'(1);
      end
    end
  end

  assign dark = blink_q & blink_mask[idx_q];
`else
  assign dark = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    case (st_q)
      BLANK: if (cnt_q == BEND) st_d = SHOW;
      SHOW: begin
        if (cnt_q == LAST) begin
          st_d  = BLANK;
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
        end
        seg_d = {~dp_mask[idx_q], seg7(nib)};
        if (disp_mask[idx_q] && !dark) an_d = ~(8'd1 << idx_q);
      end
      default: st_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fresh_q <= 1'b0;
    end
  end

  // A load on a boundary cycle lands in shadow after the old shadow has been committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      sh_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      if (boundary && pend_q) act_q <= sh_q;
      if (load) sh_q <= disp_data;
      pend_q <= load | (pend_q & ~boundary);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out     <= 8'hFF;
      seg_out    <= 8'hFF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an_out     <= an_d;
      seg_out    <= seg_d;
      load_ack   <= boundary & pend_q;
      frame_done <= boundary;
    end
  end
endmodule
